// File: rtl/fuel_pump_pkg.sv
// Shared state encoding, default configuration and width helper for the fuel pump sequencer.
package fuel_pump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_ARM = 3'd1,
        ST_RUNNING  = 3'd2,
        ST_DENIED   = 3'd3,
        ST_LOCKOUT  = 3'd4
    } fp_state_e;

    localparam int              DEF_NUM_HIDDEN    = 2;
    localparam logic [1:0]      DEF_HIDDEN_CODE   = 2'b10;
    localparam int              DEF_ARM_WINDOW    = 10;
    localparam int              DEF_MAX_FAILS     = 3;
    localparam int              DEF_LOCKOUT_TICKS = 30;

    function automatic int fail_cnt_w(input int max_fails);
        return (max_fails < 1) ? 1 : $clog2(max_fails + 1);
    endfunction

endpackage

// File: rtl/fuel_pump_sequencer_tick_countdown.sv
// Loadable down-counter stepped by the 1 Hz enable; holds at zero instead of wrapping.
module tick_countdown #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         tick_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/fuel_pump_sequencer.sv
// Anti-theft fuel pump arming FSM: brake edge with hidden code inside a timed window enables the pump.
// Define FUEL_PUMP_LOCKOUT_EN to add the timed lockout after MAX_FAILS failed attempts.
module fuel_pump_sequencer
    import fuel_pump_pkg::*;
#(
    parameter int                    NUM_HIDDEN    = DEF_NUM_HIDDEN,
    parameter logic [NUM_HIDDEN-1:0] HIDDEN_CODE   = DEF_HIDDEN_CODE,
    parameter int                    ARM_WINDOW    = DEF_ARM_WINDOW,
    parameter int                    MAX_FAILS     = DEF_MAX_FAILS,
    parameter int                    LOCKOUT_TICKS = DEF_LOCKOUT_TICKS
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                tick_1hz,
    input  logic                                ignition,
    input  logic                                brake_depressed,
    input  logic [NUM_HIDDEN-1:0]               hidden,
    output logic                                fuel_pump_power,
    output logic                                lockout,
    output logic [fail_cnt_w(MAX_FAILS)-1:0]    fail_count,
    output logic [2:0]                          state
);

    localparam int             FCW      = fail_cnt_w(MAX_FAILS);
    localparam int             WW       = $clog2(ARM_WINDOW + 1);
    localparam logic [FCW-1:0] FAIL_MAX = FCW'(MAX_FAILS);

    fp_state_e      state_q, state_d;
    logic [FCW-1:0] fail_q, fail_d, fail_inc;
    logic           brake_q;
    logic           brake_rise, code_ok;
    logic           win_load, win_zero;

    assign brake_rise = brake_depressed & ~brake_q;
    assign code_ok    = (hidden == HIDDEN_CODE);
    assign fail_inc   = (fail_q == FAIL_MAX) ? fail_q : fail_q + 1'b1;

    tick_countdown #(.W(WW)) u_window (
        .clk        (clk),
        .reset      (reset),
        .load_i     (win_load),
        .load_val_i (WW'(ARM_WINDOW)),
        .tick_i     (tick_1hz),
        .zero_o     (win_zero)
    );

`ifdef FUEL_PUMP_LOCKOUT_EN
    localparam int LW = $clog2(LOCKOUT_TICKS + 1);
    logic lock_load, lock_zero;

    tick_countdown #(.W(LW)) u_lockout (
        .clk        (clk),
        .reset      (reset),
        .load_i     (lock_load),
        .load_val_i (LW'(LOCKOUT_TICKS)),
        .tick_i     (tick_1hz),
        .zero_o     (lock_zero)
    );
`else
    logic unused_lockout_ticks;
    assign unused_lockout_ticks = ^LOCKOUT_TICKS;
`endif

    always_comb begin
        state_d  = state_q;
        fail_d   = fail_q;
        win_load = 1'b0;
`ifdef FUEL_PUMP_LOCKOUT_EN
        lock_load = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (ignition) begin
                    state_d  = ST_WAIT_ARM;
                    win_load = 1'b1;
                end
            end
            ST_WAIT_ARM: begin
                if (!ignition) begin
                    state_d = ST_IDLE;
                end else if (brake_rise && code_ok) begin
                    state_d = ST_RUNNING;
                    fail_d  = '0;
                end else if (brake_rise || (tick_1hz && win_zero)) begin
                    // A wrong press keeps the window running; only expiry leaves for DENIED.
                    fail_d = fail_inc;
                    if (!brake_rise) begin
                        state_d = ST_DENIED;
                    end
`ifdef FUEL_PUMP_LOCKOUT_EN
                    if (fail_inc == FAIL_MAX) begin
                        state_d   = ST_LOCKOUT;
                        lock_load = 1'b1;
                    end
`endif
                end
            end
            ST_RUNNING, ST_DENIED: begin
                if (!ignition) begin
                    state_d = ST_IDLE;
                end
            end
`ifdef FUEL_PUMP_LOCKOUT_EN
            ST_LOCKOUT: begin
                if (tick_1hz && lock_zero) begin
                    state_d = ST_IDLE;
                    fail_d  = '0;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            fail_q  <= '0;
            brake_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
            brake_q <= brake_depressed;
        end
    end

    assign fuel_pump_power = (state_q == ST_RUNNING);
    assign lockout         = (state_q == ST_LOCKOUT);
    assign fail_count      = fail_q;
    assign state           = state_q;

endmodule

// File: tb/tb_fuel_pump_sequencer.sv
// Directed scoreboard bench for fuel_pump_sequencer with short window and lockout settings.
module tb_fuel_pump_sequencer;
    import fuel_pump_pkg::*;

    localparam int         NH   = 2;
    localparam logic [1:0] CODE = 2'b10;
    localparam int         AW   = 4;
    localparam int         MF   = 3;
    localparam int         LT   = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       ignition = 1'b0;
    logic       brake_depressed = 1'b0;
    logic [1:0] hidden = 2'b00;
    logic       pump, lk;
    logic [1:0] fc;
    logic [2:0] st;

    fuel_pump_sequencer #(
        .NUM_HIDDEN    (NH),
        .HIDDEN_CODE   (CODE),
        .ARM_WINDOW    (AW),
        .MAX_FAILS     (MF),
        .LOCKOUT_TICKS (LT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .tick_1hz        (tick_1hz),
        .ignition        (ignition),
        .brake_depressed (brake_depressed),
        .hidden          (hidden),
        .fuel_pump_power (pump),
        .lockout         (lk),
        .fail_count      (fc),
        .state           (st)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int total = 0;
    int bad = 0;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       pump;
        logic       lk;
        logic [1:0] fc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Scoreboard monitor: compares every expectation due in the current cycle at the falling edge.
    exp_t  m_e;
    string m_n;
    initial begin
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                m_e = exp_q.pop_front();
                m_n = name_q.pop_front();
                total++;
                if (m_e.cyc != cyc || st !== m_e.st || pump !== m_e.pump ||
                    lk !== m_e.lk || fc !== m_e.fc) begin
                    bad++;
                    $display("FAIL %s: got st=%0d pump=%0b lockout=%0b fc=%0d, want st=%0d pump=%0b lockout=%0b fc=%0d (cycle %0d/%0d)",
                             m_n, st, pump, lk, fc, m_e.st, m_e.pump, m_e.lk, m_e.fc, cyc, m_e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, pending=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    task automatic step(input bit tk);
        tick_1hz = tk;
        @(posedge clk);
        #2;
        tick_1hz = 1'b0;
    endtask

    task automatic push_exp(input string nm, input logic [2:0] s, input logic p,
                            input logic l, input logic [1:0] f);
        exp_t e;
        e.cyc  = cyc;
        e.st   = s;
        e.pump = p;
        e.lk   = l;
        e.fc   = f;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic press(input logic [1:0] code, input string nm, input logic [2:0] s,
                         input logic p, input logic l, input logic [1:0] f);
        hidden          = code;
        brake_depressed = 1'b1;
        step(1'b0);
        push_exp(nm, s, p, l, f);
        brake_depressed = 1'b0;
        step(1'b0);
    endtask

    initial begin
        step(1'b0);
        step(1'b0);
        push_exp("reset", ST_IDLE, 0, 0, 0);
        reset = 1'b0;

        // Correct code after two ticks, then ignition off.
        hidden = 2'b10; ignition = 1'b1;
        step(1'b0); push_exp("t1_arm", ST_WAIT_ARM, 0, 0, 0);
        step(1'b1); step(1'b1);
        press(2'b10, "t1_run", ST_RUNNING, 1, 0, 0);
        ignition = 1'b0;
        step(1'b0); push_exp("t1_off", ST_IDLE, 0, 0, 0);

        // Window expiry: ARM_WINDOW+1 ticks with no brake.
        ignition = 1'b1;
        step(1'b0); push_exp("t2_arm", ST_WAIT_ARM, 0, 0, 0);
        repeat (4) step(1'b1);
        push_exp("t2_window_open", ST_WAIT_ARM, 0, 0, 0);
        step(1'b1); push_exp("t2_denied", ST_DENIED, 0, 0, 1);
        press(2'b10, "t2_denied_brake", ST_DENIED, 0, 0, 1);
        ignition = 1'b0;
        step(1'b0); push_exp("t2_idle", ST_IDLE, 0, 0, 1);
        ignition = 1'b1;
        step(1'b0); push_exp("t2_rearm", ST_WAIT_ARM, 0, 0, 1);
        press(2'b10, "t2_run_clears", ST_RUNNING, 1, 0, 0);
        ignition = 1'b0;
        step(1'b0); push_exp("t2_off", ST_IDLE, 0, 0, 0);

        // Repeated wrong codes.
        ignition = 1'b1;
        step(1'b0); push_exp("t3_arm", ST_WAIT_ARM, 0, 0, 0);
        press(2'b01, "t3_fail1", ST_WAIT_ARM, 0, 0, 1);
        press(2'b01, "t3_fail2", ST_WAIT_ARM, 0, 0, 2);
`ifdef FUEL_PUMP_LOCKOUT_EN
        press(2'b01, "t3_lock", ST_LOCKOUT, 0, 1, 3);
        hidden = 2'b10;
        for (int i = 0; i < 5; i++) begin
            brake_depressed = 1'b1;
            step(1'b1); push_exp("t3_lock_hold", ST_LOCKOUT, 0, 1, 3);
            brake_depressed = 1'b0;
            step(1'b0);
        end
        step(1'b1); push_exp("t3_lock_end", ST_IDLE, 0, 0, 0);
        step(1'b0); push_exp("t3_rearm", ST_WAIT_ARM, 0, 0, 0);
        ignition = 1'b0;
        step(1'b0); push_exp("t3_off", ST_IDLE, 0, 0, 0);
`else
        press(2'b01, "t3_fail3", ST_WAIT_ARM, 0, 0, 3);
        press(2'b01, "t3_fail4_sat", ST_WAIT_ARM, 0, 0, 3);
        press(2'b01, "t3_fail5_sat", ST_WAIT_ARM, 0, 0, 3);
        ignition = 1'b0;
        step(1'b0); push_exp("t3_idle", ST_IDLE, 0, 0, 3);
        ignition = 1'b1;
        step(1'b0);
        press(2'b10, "t3_clear", ST_RUNNING, 1, 0, 0);
        ignition = 1'b0;
        step(1'b0); push_exp("t3_off", ST_IDLE, 0, 0, 0);
`endif

        // Correct press on the expiry tick wins and clears the count.
        ignition = 1'b1;
        step(1'b0); push_exp("t4_arm", ST_WAIT_ARM, 0, 0, 0);
        press(2'b01, "t4_fail", ST_WAIT_ARM, 0, 0, 1);
        repeat (4) step(1'b1);
        hidden = 2'b10; brake_depressed = 1'b1;
        step(1'b1); push_exp("t4_expiry_ok", ST_RUNNING, 1, 0, 0);
        brake_depressed = 1'b0; ignition = 1'b0;
        step(1'b0); push_exp("t4_off", ST_IDLE, 0, 0, 0);

        // Wrong press on the expiry tick counts once; the next tick expires.
        ignition = 1'b1;
        step(1'b0); push_exp("t4b_arm", ST_WAIT_ARM, 0, 0, 0);
        repeat (4) step(1'b1);
        hidden = 2'b01; brake_depressed = 1'b1;
        step(1'b1); push_exp("t4b_expiry_wrong", ST_WAIT_ARM, 0, 0, 1);
        brake_depressed = 1'b0;
        step(1'b0); push_exp("t4b_still_arm", ST_WAIT_ARM, 0, 0, 1);
        step(1'b1); push_exp("t4b_denied", ST_DENIED, 0, 0, 2);
        ignition = 1'b0;
        step(1'b0); push_exp("t4b_idle", ST_IDLE, 0, 0, 2);
        ignition = 1'b1;
        step(1'b0);
        press(2'b10, "t4b_clear", ST_RUNNING, 1, 0, 0);
        ignition = 1'b0;
        step(1'b0);

        // Ignition drop beats a simultaneous correct press.
        ignition = 1'b1;
        step(1'b0); push_exp("t4c_arm", ST_WAIT_ARM, 0, 0, 0);
        hidden = 2'b10; ignition = 1'b0; brake_depressed = 1'b1;
        step(1'b0); push_exp("t4c_ign_wins", ST_IDLE, 0, 0, 0);
        brake_depressed = 1'b0;
        step(1'b0);

        // Reset while running, and while locked out.
        ignition = 1'b1;
        step(1'b0);
        press(2'b10, "t5_run", ST_RUNNING, 1, 0, 0);
        reset = 1'b1;
        step(1'b0); push_exp("t5_reset_run", ST_IDLE, 0, 0, 0);
        reset = 1'b0;
        step(1'b0); push_exp("t5_after_reset", ST_WAIT_ARM, 0, 0, 0);
`ifdef FUEL_PUMP_LOCKOUT_EN
        press(2'b01, "t5_f1", ST_WAIT_ARM, 0, 0, 1);
        press(2'b01, "t5_f2", ST_WAIT_ARM, 0, 0, 2);
        press(2'b01, "t5_lock", ST_LOCKOUT, 0, 1, 3);
        reset = 1'b1;
        step(1'b0); push_exp("t5_reset_lock", ST_IDLE, 0, 0, 0);
        reset = 1'b0;
`endif
        ignition = 1'b0;
        step(1'b0); push_exp("t5_off", ST_IDLE, 0, 0, 0);

        // Brake held across ignition-on gives no edge.
        brake_depressed = 1'b1;
        step(1'b0);
        ignition = 1'b1; hidden = 2'b10;
        step(1'b0); push_exp("t6_hold_arm", ST_WAIT_ARM, 0, 0, 0);
        step(1'b0); push_exp("t6_hold_no_edge", ST_WAIT_ARM, 0, 0, 0);
        brake_depressed = 1'b0;
        step(1'b0);
        press(2'b10, "t6_repress", ST_RUNNING, 1, 0, 0);
        ignition = 1'b0;
        step(1'b0); push_exp("t6_off", ST_IDLE, 0, 0, 0);

        repeat (3) step(1'b0);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
